// File: rtl/mult_8x8_seq_ctrl.sv
// 8x8 multiply sequencer driving one shared 4x4 multiplier core.
// Each operand pair is split into four nibble partial products (LL, LH, HL, HH).
// Each partial product is issued on its own cycle with its own core variant select.
// Returning core products are shifted and summed into a 16-bit accumulator.
module mult_8x8_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [7:0]  cfg_mode,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_sel,
  output logic        mul_issue,
  input  logic [7:0]  mul_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state_reg;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [7:0]  mode_reg;
  logic [1:0]  idx_reg;
  logic [15:0] acc_reg;

  logic        ret_valid;
  logic [1:0]  ret_idx;
  logic [15:0] ret_term;
  logic [15:0] acc_next;

  // Operands and variant select for partial product idx.
  // Index bit 1 picks the A nibble and bit 0 picks the B nibble.
  // A select field of 11 is sent to the core as exact (00).
  function automatic logic [9:0] issue_ops(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] mode, input logic [1:0] idx);
    logic [3:0] na;
    logic [3:0] nb;
    logic [1:0] sel;
    na  = idx[1] ? a[7:4] : a[3:0];
    nb  = idx[0] ? b[7:4] : b[3:0];
    sel = mode[{idx, 1'b0} +: 2];
    if (sel == 2'b11) sel = 2'b00;
    return {na, nb, sel};
  endfunction

  generate
    if (MUL_LAT == 0) begin : g_comb_core
      // A combinational core answers in the same cycle as the issue.
      assign ret_valid = mul_issue;
      assign ret_idx   = idx_reg;
    end else begin : g_pipe_core
      logic [MUL_LAT-1:0] v_reg;
      logic [1:0]         tag_reg [MUL_LAT];
      for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          // The first stage captures the issue presented to the core this cycle.
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              v_reg[gi]   <= 1'b0;
              tag_reg[gi] <= 2'd0;
            end else begin
              v_reg[gi]   <= mul_issue;
              tag_reg[gi] <= idx_reg;
            end
          end
        end else begin : g_body
          // Later stages shift the {valid, idx} tag along with the core pipeline.
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              v_reg[gi]   <= 1'b0;
              tag_reg[gi] <= 2'd0;
            end else begin
              v_reg[gi]   <= v_reg[gi-1];
              tag_reg[gi] <= tag_reg[gi-1];
            end
          end
        end
      end
      assign ret_valid = v_reg[MUL_LAT-1];
      assign ret_idx   = tag_reg[MUL_LAT-1];
    end
  endgenerate

  // Weight the returning partial product: LL by 1, LH and HL by 16, HH by 256.
  always_comb begin
    ret_term = {8'd0, mul_r};
    case (ret_idx)
      2'd0:    ret_term = {8'd0, mul_r};
      2'd3:    ret_term = {mul_r, 8'd0};
      default: ret_term = {4'd0, mul_r, 4'd0};
    endcase
    acc_next = acc_reg + ret_term;
  end

  assign in_ready = (state_reg == IDLE) && !rst;
  assign busy     = (state_reg != IDLE);

  // Transaction sequencer: accept, issue the four nibble products, drain the core, present the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= 8'd0;
      b_reg     <= 8'd0;
      mode_reg  <= 8'd0;
      idx_reg   <= 2'd0;
      acc_reg   <= 16'd0;
      mul_a     <= 4'd0;
      mul_b     <= 4'd0;
      mul_sel   <= 2'd0;
      mul_issue <= 1'b0;
      out_valid <= 1'b0;
      R         <= 16'd0;
    end else begin
      if (ret_valid) acc_reg <= acc_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= A;
            b_reg     <= B;
            mode_reg  <= cfg_mode;
            acc_reg   <= 16'd0;
            idx_reg   <= 2'd0;
            {mul_a, mul_b, mul_sel} <= issue_ops(A, B, cfg_mode, 2'd0);
            mul_issue <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx_reg == 2'd3) begin
            mul_issue <= 1'b0;
            state_reg <= (MUL_LAT > 0) ? DRAIN : DONE;
          end else begin
            idx_reg <= idx_reg + 2'd1;
            {mul_a, mul_b, mul_sel} <= issue_ops(a_reg, b_reg, mode_reg, idx_reg + 2'd1);
          end
        end
        DRAIN: begin
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // The HH return completes the sum; publish it in the same edge it is accumulated.
      if (ret_valid && ret_idx == 2'd3) begin
        out_valid <= 1'b1;
        R         <= acc_next;
        state_reg <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Bench for mult_8x8_seq_ctrl.
// Two instances are exercised: one with a combinational core (latency 0) and one with a 2-cycle core.
// A behavioural 4x4 core feeds each instance.
// Outside the return window the core drives random junk on mul_r.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  A, B, cfg_mode;
  logic        out_ready;
  logic        in_valid_w  [2];
  logic        in_ready_w  [2];
  logic [3:0]  mul_a_w     [2];
  logic [3:0]  mul_b_w     [2];
  logic [1:0]  mul_sel_w   [2];
  logic        mul_issue_w [2];
  logic [7:0]  mul_r_w     [2];
  logic        out_valid_w [2];
  logic [15:0] r_w         [2];
  logic        busy_w      [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_8x8_seq_ctrl #(.MUL_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
    .A(A), .B(B), .cfg_mode(cfg_mode),
    .mul_a(mul_a_w[0]), .mul_b(mul_b_w[0]), .mul_sel(mul_sel_w[0]), .mul_issue(mul_issue_w[0]),
    .mul_r(mul_r_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .R(r_w[0]), .busy(busy_w[0])
  );

  mult_8x8_seq_ctrl #(.MUL_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
    .A(A), .B(B), .cfg_mode(cfg_mode),
    .mul_a(mul_a_w[1]), .mul_b(mul_b_w[1]), .mul_sel(mul_sel_w[1]), .mul_issue(mul_issue_w[1]),
    .mul_r(mul_r_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .R(r_w[1]), .busy(busy_w[1])
  );

  // Behavioural 4x4 core variants: exact, N1 (LSB flipped), R2 (two LSBs dropped).
  function automatic logic [7:0] core_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    logic [7:0] p;
    p = 8'(a * b);
    case (s)
      2'd1:    return p ^ 8'h01;
      2'd2:    return p & 8'hFC;
      default: return p;
    endcase
  endfunction

  logic [7:0] junk = 8'h5A;
  logic [8:0] d0 = '0;
  logic [8:0] d1 = '0;
  always @(negedge clk) junk <= 8'($urandom);
  always @(posedge clk) begin
    d1 <= d0;
    d0 <= {mul_issue_w[1], core_fn(mul_a_w[1], mul_b_w[1], mul_sel_w[1])};
  end
  assign mul_r_w[0] = mul_issue_w[0] ? core_fn(mul_a_w[0], mul_b_w[0], mul_sel_w[0]) : junk;
  assign mul_r_w[1] = d1[8] ? d1[7:0] : junk;

  // Reference model: four nibble products in issue order LL, LH, HL, HH.
  function automatic logic [1:0] eff_sel(input logic [7:0] m, input int k);
    logic [1:0] f;
    f = m[2*k +: 2];
    return (f == 2'd3) ? 2'd0 : f;
  endfunction

  function automatic logic [3:0] nib(input logic [7:0] x, input int hi);
    return (hi != 0) ? x[7:4] : x[3:0];
  endfunction

  function automatic logic [15:0] ref_r(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    int sum;
    int sh;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      sh = (k == 0) ? 0 : (k == 3) ? 8 : 4;
      sum += int'(core_fn(nib(a, k / 2), nib(b, k % 2), eff_sel(m, k))) << sh;
    end
    return 16'(sum);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input int w);
    check("rst_in_ready", 32'(in_ready_w[w]), 0);
    check("rst_mul_issue", 32'(mul_issue_w[w]), 0);
    check("rst_mul_a", 32'(mul_a_w[w]), 0);
    check("rst_mul_b", 32'(mul_b_w[w]), 0);
    check("rst_mul_sel", 32'(mul_sel_w[w]), 0);
    check("rst_out_valid", 32'(out_valid_w[w]), 0);
    check("rst_R", 32'(r_w[w]), 0);
    check("rst_busy", 32'(busy_w[w]), 0);
  endtask

  // One transaction on instance w. The task is entered 1 time unit after a rising edge.
  // hold = number of cycles out_ready stays low once the result is valid.
  task automatic run_txn(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] m, input int hold);
    int lat;
    int cyc;
    logic [15:0] exp_r;
    lat   = (w != 0) ? 2 : 0;
    exp_r = ref_r(a, b, m);
    out_ready = (hold == 0);
    A = a; B = b; cfg_mode = m;
    in_valid_w[w] = 1'b1;
    check("in_ready_idle", 32'(in_ready_w[w]), 1);
    @(posedge clk); #1;
    in_valid_w[w] = 1'b0;
    A = 8'($urandom); B = 8'($urandom); cfg_mode = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      check("issue_strobe", 32'(mul_issue_w[w]), 1);
      check("issue_a", 32'(mul_a_w[w]), 32'(nib(a, k / 2)));
      check("issue_b", 32'(mul_b_w[w]), 32'(nib(b, k % 2)));
      check("issue_sel", 32'(mul_sel_w[w]), 32'(eff_sel(m, k)));
      check("busy_issue", 32'(busy_w[w]), 1);
      @(posedge clk); #1;
    end
    cyc = 5;
    while (!out_valid_w[w] && cyc < 5 + lat + 10) begin
      check("no_issue_drain", 32'(mul_issue_w[w]), 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(5 + lat));
    check("out_valid", 32'(out_valid_w[w]), 1);
    check("R", 32'(r_w[w]), 32'(exp_r));
    for (int h = 0; h < hold; h++) begin
      in_valid_w[w] = 1'b1; A = 8'd1; B = 8'd1; cfg_mode = 8'd0;
      check("bp_out_valid", 32'(out_valid_w[w]), 1);
      check("bp_R", 32'(r_w[w]), 32'(exp_r));
      check("bp_in_ready", 32'(in_ready_w[w]), 0);
      @(posedge clk); #1;
    end
    in_valid_w[w] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_out_valid", 32'(out_valid_w[w]), 0);
    check("post_R_held", 32'(r_w[w]), 32'(exp_r));
    check("post_busy", 32'(busy_w[w]), 0);
    $display("txn lat=%0d A=%0d B=%0d cfg=%02h R=%0d expected=%0d cycles=%0d", lat, a, b, m, r_w[w], exp_r, cyc);
  endtask

  initial begin
    in_valid_w[0] = 1'b0;
    in_valid_w[1] = 1'b0;
    A = 8'd0; B = 8'd0; cfg_mode = 8'd0; out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready0", 32'(in_ready_w[0]), 1);
    check("idle_in_ready2", 32'(in_ready_w[1]), 1);

    run_txn(0, 8'd200, 8'd150, 8'h00, 0);
    run_txn(0, 8'd255, 8'd255, 8'hFF, 0);
    run_txn(0, 8'($urandom), 8'($urandom), 8'hA5, 0);
    run_txn(1, 8'd17, 8'd34, 8'h00, 0);
    run_txn(1, 8'd255, 8'd255, 8'hA5, 0);
    run_txn(0, 8'($urandom), 8'($urandom), 8'($urandom), 3);
    run_txn(0, 8'd1, 8'd1, 8'h00, 0);
    run_txn(1, 8'($urandom), 8'($urandom), 8'($urandom), 3);
    run_txn(1, 8'd1, 8'd1, 8'h00, 0);
    for (int i = 0; i < 16; i++)
      run_txn(i % 2, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

    // Abort a latency-2 transaction during its HL (idx2) issue.
    A = 8'($urandom); B = 8'($urandom); cfg_mode = 8'($urandom);
    in_valid_w[1] = 1'b1;
    @(posedge clk); #1;
    in_valid_w[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_at_issue", 32'(mul_issue_w[1]), 1);
    #2 rst = 1'b1;
    #1;
    check_reset_vals(1);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_valid", 32'(out_valid_w[1]), 0);
    run_txn(1, 8'd3, 8'd5, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
